// File: rtl/counter_ctrl.sv
// Prescaled run/pause/done controller driving an external 8-bit counter; all outputs registered.
// Optional wrap-event counter output enabled by defining COUNTER_CTRL_WRAP_CNT_EN.
module counter_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        one_shot,
  input  logic [15:0] div,
  input  logic [7:0]  limit,
  input  logic [7:0]  cnt_q,
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state
`ifdef COUNTER_CTRL_WRAP_CNT_EN
  ,
  output logic [7:0]  wraps
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic        cnt_en_d, cnt_clr_d, done_d;
  logic [8:0]  eff_cnt;
  logic        tick, at_limit;
`ifdef COUNTER_CTRL_WRAP_CNT_EN
  logic        wrap_evt;
`endif

  // cnt_en/cnt_clr issued last cycle have not reached cnt_q yet, so fold them
  // in; otherwise back-to-back ticks would overshoot the limit by one.
  always_comb begin
    eff_cnt  = cnt_clr ? 9'd0 : ({1'b0, cnt_q} + {8'd0, cnt_en});
    at_limit = (eff_cnt >= {1'b0, limit});
    tick     = (presc_q == div);

    state_d   = state_q;
    presc_d   = presc_q;
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;
    done_d    = 1'b0;
`ifdef COUNTER_CTRL_WRAP_CNT_EN
    wrap_evt  = 1'b0;
`endif

    if (clear) begin
      state_d   = IDLE;
      presc_d   = 16'd0;
      cnt_clr_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          presc_d = 16'd0;
          if (!stop && start) state_d = RUN;
        end
        PAUSE: begin
          if (!stop && start) state_d = RUN;
        end
        DONE: begin
          presc_d = 16'd0;
          if (!stop && start) begin
            state_d   = RUN;
            cnt_clr_d = 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (tick) begin
            presc_d = 16'd0;
            if (!at_limit) begin
              cnt_en_d = 1'b1;
            end else if (one_shot) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              cnt_clr_d = 1'b1;
`ifdef COUNTER_CTRL_WRAP_CNT_EN
              wrap_evt  = 1'b1;
`endif
            end
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= 16'd0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_en  <= cnt_en_d;
      cnt_clr <= cnt_clr_d;
      done    <= done_d;
      busy    <= (state_d == RUN);
    end
  end

  assign state = state_q;

`ifdef COUNTER_CTRL_WRAP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wraps <= 8'd0;
    end else if (clear) begin
      wraps <= 8'd0;
    end else if (wrap_evt && (wraps != 8'hFF)) begin
      wraps <= wraps + 8'd1;
    end
  end
`endif

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; forces reset state immediately, independent of clk.
REQ-003 SHALL have port: start  input  1  command; begin or resume counting.
REQ-004 SHALL have port: stop  input  1  command; pause counting.
REQ-005 SHALL have port: clear  input  1  command; abort and zero the counter.
REQ-006 SHALL have port: one_shot  input  1  1 = halt at limit; 0 = wrap to 0 at limit.
REQ-007 SHALL have port: div  input  16  prescale; one tick every div+1 clk cycles.
REQ-008 SHALL have port: limit  input  8  terminal count value.
REQ-009 SHALL have port: cnt_q  input  8  current value of the controlled 8-bit counter.
REQ-010 SHALL have port: cnt_en  output  1  one-cycle increment enable to the counter.
REQ-011 SHALL have port: cnt_clr  output  1  one-cycle synchronous clear to the counter.
REQ-012 SHALL have port: busy  output  1  high while state is RUN.
REQ-013 SHALL have port: done  output  1  one-cycle pulse on one-shot completion.
REQ-014 SHALL have port: state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-015 SHALL register all outputs (no combinational input-to-output paths).
REQ-016 SHALL apply command priority clear > stop > start when several are high in one cycle.
REQ-017 SHALL, on clear in any state: go IDLE, zero prescaler, assert cnt_clr for one cycle, cnt_en low.
REQ-018 SHALL, on start in IDLE or PAUSE: go RUN; start in RUN ignored.
REQ-019 SHALL, on start in DONE: go RUN and assert cnt_clr for one cycle.
REQ-020 SHALL, on stop in RUN: go PAUSE holding prescaler value (resume keeps tick phase); stop elsewhere ignored.
REQ-021 SHALL, in RUN, increment the 16-bit prescaler each cycle; when prescaler == div, generate a tick and reload prescaler to 0.
REQ-022 SHALL, with div = 0, tick every RUN cycle; first tick asserted div+1 cycles after the edge that accepted start from IDLE.
REQ-023 SHALL, at a tick with cnt_q < limit, assert cnt_en for exactly one cycle.
REQ-024 SHALL, at a tick with cnt_q >= limit and one_shot = 1: no cnt_en, go DONE, pulse done one cycle.
REQ-025 SHALL, at a tick with cnt_q >= limit and one_shot = 0: assert cnt_clr (not cnt_en) for one cycle and stay RUN.
REQ-026 SHALL sample div, limit, one_shot live every cycle; mid-run changes take effect at next compare.
REQ-027 SHALL never assert cnt_en and cnt_clr in the same cycle.
REQ-028 SHALL hold prescaler at 0 in IDLE and DONE.

Reset
REQ-029 SHALL, while reset = 1: state=IDLE, prescaler=0, cnt_en=0, cnt_clr=0, busy=0, done=0.
REQ-030 SHALL, on reset assertion mid-RUN, drop cnt_en/done immediately and resume only on a new start.

Configuration
REQ-031 SHALL, with macro COUNTER_CTRL_WRAP_CNT_EN defined, add output wraps (8 bits) counting REQ-025 wrap events, saturating at 255, zeroed by reset and clear.
REQ-032 SHALL, without COUNTER_CTRL_WRAP_CNT_EN, omit the wraps port and its logic entirely; all other behaviour identical.

Verification
REQ-033 SHALL cover: reset, div=3, start one cycle -> cnt_en pulses every 4 cycles, first pulse 4 cycles after start edge.
REQ-034 SHALL cover: one_shot=1, limit=5, div=0, cnt_q modeled -> 5 cnt_en pulses, then done=1 one cycle, state=3, busy=0.
REQ-035 SHALL cover: one_shot=0, limit=2, div=0 -> cnt_en,cnt_en,cnt_clr repeating; wraps increments per cnt_clr when macro defined.
REQ-036 SHALL cover: stop at prescaler=2 with div=7, start 10 cycles later -> next cnt_en 6 cycles after resume edge.
REQ-037 SHALL cover: clear, stop, start high together in RUN -> state=0, cnt_clr=1 one cycle, cnt_en=0.
REQ-038 SHALL cover: reset pulsed asynchronously between clk edges mid-RUN -> all outputs 0 before next edge, state=0.
